serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 34 +++
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and serial-operand bus between the serial adder controller
// and its requester / external operand shift registers.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             cin;
    logic             sr_load;
    logic             a_bit;
    logic             b_bit;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output start, cin, a_bit, b_bit,
        input  sr_load, busy, done, sum, cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, cin, a_bit, b_bit,
        output sr_load, busy, done, sum, cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: loads two external LSB-first shift registers
// and accumulates WIDTH sum bits. Optional ovf port: SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s;
    logic             w_c;
    logic             w_last;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             r_ovf;
`endif

    assign w_s    = bus.a_bit ^ bus.b_bit ^ r_carry;
    assign w_c    = (bus.a_bit & bus.b_bit) | (bus.a_bit & r_carry)
                  | (bus.b_bit & r_carry);
    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_next      = r_state;
        bus.sr_load = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_LOAD;
            end
            S_LOAD: begin
                bus.sr_load = 1'b1;
                bus.busy    = 1'b1;
                w_next      = S_SHIFT;
            end
            S_SHIFT: begin
                bus.busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) r_carry <= bus.cin;
                end
                S_LOAD: begin
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_c;
                    // Hold the counter on the last bit so it never wraps.
                    if (w_last) begin
                        r_cout <= w_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        r_ovf  <= r_carry ^ w_c;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl with behavioural LSB-first
// operand shift registers.
module tb_serial_adder_ctrl;
    logic clk;
    logic reset;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [15:0] sra;
    logic [15:0] srb;
    int checks;
    int failures;

    serial_adder_ctrl_if #(.WIDTH(16)) bus ();

    serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sr_load) begin
            sra <= opa;
            srb <= opb;
        end else begin
            sra <= sra >> 1;
            srb <= srb >> 1;
        end
    end
    assign bus.a_bit = sra[0];
    assign bus.b_bit = srb[0];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input bit inj,
                          output int lat, output int nld);
        opa = a;
        opb = b;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cin   = c;
        lat = 0;
        nld = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (inj && lat == 6) bus.start = 1'b1;
            if (inj && lat == 7) bus.start = 1'b0;
            if (bus.sr_load) nld++;
        end while (!bus.done && lat < 40);
    endtask

    initial begin
        int lat;
        int nld;
        int nd;
        int dt[$];
        checks    = 0;
        failures  = 0;
        opa       = '0;
        opb       = '0;
        bus.start = 1'b0;
        bus.cin   = 1'b0;
        reset     = 1'b1;

        vt[0] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sr_load", {31'd0, bus.sr_load}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].c, 1'b0, lat, nld);
            chk($sformatf("v%0d_latency", i), lat, 32'd18);
            chk($sformatf("v%0d_sr_load_cycles", i), nld, 32'd1);
            chk($sformatf("v%0d_sum", i), {16'd0, bus.sum}, {16'd0, vt[i].s});
            chk($sformatf("v%0d_cout", i), {31'd0, bus.cout},
                {31'd0, vt[i].co});
`ifdef SERIAL_ADDER_OVERFLOW_EN
            chk($sformatf("v%0d_ovf", i), {31'd0, bus.ovf},
                {31'd0, vt[i].ov});
`endif
            chk($sformatf("v%0d_done_busy", i), {31'd0, bus.busy}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // Second start during SHIFT must be ignored.
        run_op(16'h1234, 16'h4321, 1'b1, 1'b1, lat, nld);
        chk("inj_latency", lat, 32'd18);
        chk("inj_sum", {16'd0, bus.sum}, 32'h5556);
        chk("inj_cout", {31'd0, bus.cout}, 32'd0);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        chk("inj_extra_done", nd, 32'd0);
        chk("inj_sum_held", {16'd0, bus.sum}, 32'h5556);

        // Reset in the middle of SHIFT.
        opa = 16'h1234;
        opb = 16'h4321;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_sum", {16'd0, bus.sum}, 32'd0);
        chk("abort_cout", {31'd0, bus.cout}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        run_op(16'h0003, 16'h0005, 1'b0, 1'b0, lat, nld);
        chk("post_rst_latency", lat, 32'd18);
        chk("post_rst_sum", {16'd0, bus.sum}, 32'h0008);

        // start held high: back-to-back operations every 19 cycles.
        repeat (3) @(posedge clk);
        opa = 16'h0001;
        opb = 16'h0001;
        @(negedge clk);
        bus.start = 1'b1;
        bus.cin   = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dt.push_back(i);
                chk($sformatf("b2b_sum_%0d", i), {16'd0, bus.sum}, 32'h0002);
            end
        end
        bus.start = 1'b0;
        chk("b2b_count", dt.size(), 32'd3);
        if (dt.size() == 3) begin
            chk("b2b_first", dt[0], 32'd18);
            chk("b2b_gap1", dt[1] - dt[0], 32'd19);
            chk("b2b_gap2", dt[2] - dt[1], 32'd19);
        end
        repeat (30) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
